// File: rtl/datamem_arb_pkg.sv
// datamem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   port_t    : requester identity (P0 = CPU load/store unit, P1 = DMA/loader)
//   PKG_DW    : default data width; BE_W is the matching byte-enable width
//   be_merge  : byte-wise merge of a store into an existing word (default width)
// Configuration macro used by the arbiter: DATAMEM_ARB_RR_EN (round-robin).
package datamem_arb_pkg;

    typedef enum logic {P0 = 1'b0, P1 = 1'b1} port_t;

    localparam int PKG_DW = 32;
    localparam int BE_W   = PKG_DW / 8;

    // Byte i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [PKG_DW-1:0] be_merge(input logic [PKG_DW-1:0] old_word,
                                                   input logic [PKG_DW-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
        logic [PKG_DW-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/datamem_be_merge.sv
// datamem_be_merge: combinational byte merge on the memory write path.
//   old_word  in  DW    current memory word (combinational read data)
//   new_word  in  DW    store data from the granted requester
//   be        in  DW/8  byte enables
//   merged    out DW    full word written to memory
module datamem_be_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   merged
);

    for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_byte
        assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: shares a single-port data memory between the CPU (port 0)
// and the DMA/loader (port 1). At most one access is granted per cycle; stores
// are merged against the current word so the memory only sees full-word writes;
// load data is returned registered one cycle after the grant.
//   clk, rst_n              clock, synchronous active-low reset
//   p{0,1}_req/we/addr/wdata/be  request (held until gnt)
//   p{0,1}_gnt              combinational accept
//   p{0,1}_rvalid/rdata     registered load response
//   mem_we/mem_a/mem_wd     memory drive; mem_rd combinational read data
// Macro DATAMEM_ARB_RR_EN: round-robin arbitration instead of fixed priority
// with MAX_WAIT anti-starvation.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p0_req,
    input  logic                      p0_we,
    input  logic [ADDRESS_WIDTH-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p0_be,
    output logic                      p0_gnt,
    output logic                      p0_rvalid,
    output logic [DATA_WIDTH-1:0]     p0_rdata,
    input  logic                      p1_req,
    input  logic                      p1_we,
    input  logic [ADDRESS_WIDTH-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p1_be,
    output logic                      p1_gnt,
    output logic                      p1_rvalid,
    output logic [DATA_WIDTH-1:0]     p1_rdata,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_a,
    output logic [DATA_WIDTH-1:0]     mem_wd,
    input  logic [DATA_WIDTH-1:0]     mem_rd
);

    logic                    sel_p1;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_be;

`ifdef DATAMEM_ARB_RR_EN
    // Round-robin: on contention the port that was not granted last wins.
    port_t last_gnt;

    assign sel_p1 = p1_req & (~p0_req | (last_gnt == P0));

    always_ff @(posedge clk) begin
        if (!rst_n)      last_gnt <= P1;
        else if (p0_gnt) last_gnt <= P0;
        else if (p1_gnt) last_gnt <= P1;
    end
`else
    // Fixed priority P0 > P1; a P1 refused MAX_WAIT times in a row is forced through.
    localparam int WCW = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
    logic [WCW-1:0] wait_cnt;

    assign sel_p1 = p1_req & (~p0_req | (wait_cnt == WCW'(MAX_WAIT)));

    always_ff @(posedge clk) begin
        if (!rst_n || !p1_req || p1_gnt) wait_cnt <= '0;
        else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end
`endif

    // Grants are held off during reset so nothing commits on the reset edge.
    assign p1_gnt = rst_n & sel_p1;
    assign p0_gnt = rst_n & p0_req & ~sel_p1;

    assign mem_a     = sel_p1 ? p1_addr  : p0_addr;
    assign sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
    assign sel_be    = sel_p1 ? p1_be    : p0_be;
    assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);

    datamem_be_merge #(.DATA_WIDTH(DATA_WIDTH)) u_be_merge (
        .old_word (mem_rd),
        .new_word (sel_wdata),
        .be       (sel_be),
        .merged   (mem_wd)
    );

    // Load responses: capture the combinational read on the grant edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_rd;
            if (p1_gnt && !p1_we) p1_rdata <= mem_rd;
        end
    end

endmodule
